fir_sample_source: RTL and testbench

Programmable sample sequencer that drives the input side of the generic FIR filter (`i_ce`/`i_sample`) inside the accelerator. Software preloads a short signed sample buffer through a write port, then starts playback. The block emits one sample per strobe at a programmable rate, either once or looped. It replaces hand-written stimulus and lets the core feed the filter with impulses, steps and test vectors at runtime.

---
 rtl/fir_sample_source.sv | 117 +++++++++++
 tb/tb_fir_sample_source.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_source.sv
// fir_sample_source: plays a preloaded signed sample buffer into a FIR input
// port at a programmable strobe rate, either once or looped.
`default_nettype none

module fir_sample_source #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int RATEW = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic signed [DW-1:0] i_wr_data,
  input  logic [AW-1:0]        i_last,
  input  logic [RATEW-1:0]     i_rate,
  input  logic                 i_loop,
  input  logic                 i_start,
  input  logic                 i_stop,
  output logic                 o_ce,
  output logic signed [DW-1:0] o_sample,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  logic signed [DW-1:0] buf_q [DEPTH];

  state_t               state_q;
  logic [AW-1:0]        ptr_q;
  logic [AW-1:0]        last_q;
  logic [RATEW-1:0]     cnt_q;
  logic [RATEW-1:0]     rate_q;
  logic                 loop_q;
  logic                 fin_q;
  logic                 ce_q;
  logic                 busy_q;
  logic                 done_q;
  logic signed [DW-1:0] sample_q;

  // Sample storage is deliberately not reset; software loads it before use.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      buf_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      rate_q   <= '0;
      loop_q   <= 1'b0;
      fin_q    <= 1'b0;
      ce_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sample_q <= '0;
    end else begin
      ce_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_stop) begin
            rate_q  <= i_rate;
            last_q  <= i_last;
            loop_q  <= i_loop;
            ptr_q   <= '0;
            cnt_q   <= i_rate;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) begin
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (fin_q) begin
            // Final strobe went out last cycle: leave RUN with the done pulse.
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            sample_q <= buf_q[ptr_q];
            ce_q     <= 1'b1;
            cnt_q    <= rate_q;
            if (ptr_q != last_q) begin
              ptr_q <= ptr_q + 1'b1;
            end else if (loop_q) begin
              ptr_q <= '0;
            end else begin
              fin_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ce     = ce_q;
  assign o_sample = sample_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_sample_source.sv
// tb_fir_sample_source: directed plus randomized playback runs checked
// against a cycle-offset schedule computed from the rate/length rules.
`default_nettype none

module tb_fir_sample_source;

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_wr_en;
  logic [3:0]        i_wr_addr;
  logic signed [11:0] i_wr_data;
  logic [3:0]        i_last;
  logic [7:0]        i_rate;
  logic              i_loop;
  logic              i_start;
  logic              i_stop;
  logic              o_ce;
  logic signed [11:0] o_sample;
  logic              o_busy;
  logic              o_done;

  int checks   = 0;
  int failures = 0;
  logic signed [11:0] mem_m [16];
  logic signed [11:0] last_s;

  fir_sample_source dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_last    (i_last),
    .i_rate    (i_rate),
    .i_loop    (i_loop),
    .i_start   (i_start),
    .i_stop    (i_stop),
    .o_ce      (o_ce),
    .o_sample  (o_sample),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int addr, input int data);
    i_wr_en   = 1'b1;
    i_wr_addr = 4'(addr);
    i_wr_data = 12'(data);
    mem_m[addr] = 12'(data);
    @(negedge clk);
    i_wr_en = 1'b0;
  endtask

  // Runs one playback from the current negedge. t counts cycles after the
  // start edge. Optional stop (stop_at) and one mid-run write (wt) are driven
  // during the given cycle and take effect at the following edge.
  task automatic play(input int r, input int last, input bit lp, input int stop_at,
                      input int wt, input int waddr, input int wdata);
    int len, tdone, tend, k, idx;
    bit ce_e, busy_e, done_e;
    len   = last + 1;
    tdone = len * (r + 1) + 1;
    tend  = (stop_at >= 0) ? stop_at + 3 : tdone;
    i_rate  = 8'(r);
    i_last  = 4'(last);
    i_loop  = lp;
    i_start = 1'b1;
    for (int t = 0; t <= tend; t++) begin
      @(negedge clk);
      i_start = (t == 1);
      i_stop  = (t == stop_at);
      i_rate  = 8'($urandom);
      i_last  = 4'($urandom);
      i_loop  = 1'($urandom);
      k = t - (r + 1);
      if (stop_at >= 0 && t > stop_at) begin
        ce_e = 0; busy_e = 0; done_e = 0;
      end else begin
        ce_e   = (k >= 0) && (k % (r + 1) == 0) && (lp || (k / (r + 1) < len));
        busy_e = lp ? 1'b1 : (t < tdone);
        done_e = !lp && (t == tdone);
      end
      if (ce_e) begin
        idx = (k / (r + 1)) % len;
        last_s = mem_m[idx];
      end
      chk("ce", 32'(o_ce), 32'(ce_e));
      chk("busy", 32'(o_busy), 32'(busy_e));
      chk("done", 32'(o_done), 32'(done_e));
      chk("sample", 32'(o_sample), 32'(last_s));
      if (t == wt) begin
        i_wr_en = 1'b1; i_wr_addr = 4'(waddr); i_wr_data = 12'(wdata);
      end else begin
        i_wr_en = 1'b0;
      end
      if (wt >= 0 && t == wt + 1) mem_m[waddr] = 12'(wdata);
    end
    i_stop  = 1'b0;
    i_wr_en = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_wr_en = 0; i_wr_addr = 0; i_wr_data = 0;
    i_last = 0; i_rate = 0; i_loop = 0; i_start = 0; i_stop = 0;
    last_s = '0;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    #12;
    chk("rst_ce", 32'(o_ce), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_sample", 32'(o_sample), 0);
    @(negedge clk);
    i_reset = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, 0);

    // Impulse
    wr(0, 1);
    play(0, 7, 0, -1, -1, 0, 0);
    @(negedge clk);

    // Rate 3 with sign extremes, then restart on the done cycle
    wr(0, -5); wr(1, 2047); wr(2, -2048);
    play(3, 2, 0, -1, -1, 0, 0);
    play(1, 1, 0, -1, -1, 0, 0);
    @(negedge clk);

    // Loop then stop
    wr(0, 7); wr(1, -7);
    play(0, 1, 1, 20, -1, 0, 0);

    // Hazards: early write to buf[3] is seen, write on buf[2]'s read edge is not
    for (int i = 0; i < 6; i++) wr(i, 100 + i);
    play(2, 5, 0, -1, 5, 3, -300);
    @(negedge clk);
    play(2, 5, 0, -1, 8, 2, 555);
    @(negedge clk);

    // Start and stop together while idle
    i_start = 1'b1; i_stop = 1'b1;
    @(negedge clk);
    chk("ss_busy", 32'(o_busy), 0);
    chk("ss_ce", 32'(o_ce), 0);
    i_start = 1'b0; i_stop = 1'b0;
    @(negedge clk);
    chk("ss_busy2", 32'(o_busy), 0);

    // Randomized one-shot and looped runs
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 16; i++) wr(i, int'($urandom_range(0, 4095)));
      play(int'($urandom_range(0, 4)), int'($urandom_range(0, 15)), 0, -1,
           int'($urandom_range(1, 4)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 4095)));
      @(negedge clk);
      play(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), 1,
           int'($urandom_range(2, 40)), -1, 0, 0);
    end

    // Asynchronous reset in the middle of a back-to-back looped run
    wr(0, 9); wr(1, -9);
    i_rate = 0; i_last = 1; i_loop = 1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 i_reset = 1'b1;
    #1;
    chk("arst_ce", 32'(o_ce), 0);
    chk("arst_busy", 32'(o_busy), 0);
    chk("arst_done", 32'(o_done), 0);
    chk("arst_sample", 32'(o_sample), 0);
    @(negedge clk);
    i_reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("post_rst_ce", 32'(o_ce), 0);
      chk("post_rst_busy", 32'(o_busy), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
